// File: rtl/i2c_master.sv
// i2c_master: single-master I2C byte engine driven by START / WRITE / READ / STOP commands.
// Define I2C_MASTER_CLOCK_STRETCH_EN to let a slave hold SCL low and stall the bit timing.
module i2c_master #(
  parameter int CLK_RATE = 28000000,
  parameter int I2C_RATE = 100000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_ack,
  output logic       cmd_ready,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       ack_err,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);
  localparam int QP = CLK_RATE / (4 * I2C_RATE);
  localparam int CW = (QP > 1) ? $clog2(QP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QP - 1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic [3:0]    bitIdx_q, bitIdx_d;
  logic          isRead_q, isRead_d;
  logic [7:0]    wrData_q, wrData_d;
  logic          rdAck_q, rdAck_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rdData_q, rdData_d;
  logic          ackErr_q, ackErr_d;
  logic          sclHold_q, sdaHold_q;

  logic active;
  logic stretch;
  logic tick;
  logic sclDrive;
  logic sdaDrive;
  logic bitSda;

  assign active = (state_q == START) || (state_q == BIT) || (state_q == STOP);

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
  assign stretch = active && (quarter_q == 2'd1) && sclDrive && !scl_i;
`else
  logic unusedSclI;
  assign unusedSclI = scl_i;
  assign stretch    = 1'b0;
`endif

  assign tick = active && !stretch && (cnt_q == CNT_LAST);

  // Line levels per phase/quarter; outside a phase the last driven levels are held.
  always_comb begin
    sclDrive = sclHold_q;
    sdaDrive = sdaHold_q;
    bitSda   = 1'b1;
    if (isRead_q) begin
      bitSda = (bitIdx_q == 4'd8) ? ~rdAck_q : 1'b1;
    end else if (bitIdx_q != 4'd8) begin
      bitSda = wrData_q[3'd7 - bitIdx_q[2:0]];
    end
    case (state_q)
      START: begin
        sclDrive = (quarter_q != 2'd3);
        sdaDrive = (quarter_q < 2'd2);
      end
      BIT: begin
        sclDrive = (quarter_q == 2'd1) || (quarter_q == 2'd2);
        sdaDrive = bitSda;
      end
      STOP: begin
        sclDrive = (quarter_q != 2'd0);
        sdaDrive = quarter_q[1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    bitIdx_d  = bitIdx_q;
    isRead_d  = isRead_q;
    wrData_d  = wrData_q;
    rdAck_d   = rdAck_q;
    shift_d   = shift_q;
    rdData_d  = rdData_q;
    ackErr_d  = ackErr_q;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        quarter_d = 2'd0;
        bitIdx_d  = 4'd0;
        if (cmd_valid) begin
          case (cmd)
            CMD_START: state_d = START;
            CMD_WRITE: begin
              state_d  = BIT;
              isRead_d = 1'b0;
              wrData_d = wr_data;
              ackErr_d = 1'b0;
            end
            CMD_READ: begin
              state_d  = BIT;
              isRead_d = 1'b1;
              rdAck_d  = rd_ack;
            end
            default: state_d = STOP;
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        if (tick) begin
          cnt_d     = '0;
          quarter_d = quarter_q + 2'd1;
          // Mid-SCL-high sample point: read data bits and the slave's write acknowledge.
          if ((state_q == BIT) && (quarter_q == 2'd1)) begin
            if (isRead_q && (bitIdx_q != 4'd8)) begin
              shift_d = {shift_q[6:0], sda_i};
            end else if (!isRead_q && (bitIdx_q == 4'd8)) begin
              ackErr_d = sda_i;
            end
          end
          if (quarter_q == 2'd3) begin
            if ((state_q == BIT) && (bitIdx_q != 4'd8)) begin
              bitIdx_d = bitIdx_q + 4'd1;
            end else begin
              state_d = DONE;
              if ((state_q == BIT) && isRead_q) begin
                rdData_d = shift_q;
              end
            end
          end
        end else if (!stretch) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quarter_q <= 2'd0;
      bitIdx_q  <= 4'd0;
      isRead_q  <= 1'b0;
      wrData_q  <= 8'h00;
      rdAck_q   <= 1'b0;
      shift_q   <= 8'h00;
      rdData_q  <= 8'h00;
      ackErr_q  <= 1'b0;
      sclHold_q <= 1'b1;
      sdaHold_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
      bitIdx_q  <= bitIdx_d;
      isRead_q  <= isRead_d;
      wrData_q  <= wrData_d;
      rdAck_q   <= rdAck_d;
      shift_q   <= shift_d;
      rdData_q  <= rdData_d;
      ackErr_q  <= ackErr_d;
      sclHold_q <= sclDrive;
      sdaHold_q <= sdaDrive;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign rd_data   = rdData_q;
  assign ack_err   = ackErr_q;
  assign scl_o     = sclDrive;
  assign sda_o     = sdaDrive;

endmodule
